// File: rtl/grant_sequencer_if.sv
// Request/grant bundle between a requester block and grant_sequencer.
// The grant side (slave) drives sel/sel_valid/busy into the 2-to-4 decoder stage.
interface grant_sequencer_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       sel_valid;
    logic       busy;

    modport master (
        output req,
        output done,
        input  sel,
        input  sel_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output sel_valid,
        output busy
    );
endinterface

// File: rtl/grant_sequencer.sv
// Four-channel round-robin grant sequencer feeding a 2-to-4 decoder (sel -> x, sel_valid -> enable).
// Define SEL_GAP_EN to insert one dead cycle between grants; default build grants back-to-back.
module grant_sequencer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    grant_sequencer_if.slave  bus
);

`ifdef SEL_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] sel_reg, sel_next;
    logic       valid_reg, valid_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [7:0] cnt_reg, cnt_next;

    // Candidate channels in priority order starting at the pointer.
    logic [1:0] cand [4];
    logic [3:0] hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = ptr_reg + 2'(gi);
            assign hit[gi]  = bus.req[cand[gi]];
        end
    endgenerate

    logic       win_any;
    logic [1:0] win_idx;
    logic       grant_end;
    logic       do_arb;

    always_comb begin
        win_any = |hit;
        win_idx = cand[0];
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                win_idx = cand[i];
            end
        end
    end

    // done and an expired count together still end the grant only once.
    assign grant_end = bus.done | (cnt_reg == 8'd0) | ~bus.req[sel_reg];

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        do_arb     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    do_arb = 1'b1;
                end else begin
                    valid_next = 1'b0;
                end
            end
            GRANT: begin
                if (grant_end) begin
`ifdef SEL_GAP_EN
                    valid_next = 1'b0;
                    state_next = GAP;
`else
                    if (win_any) begin
                        do_arb = 1'b1;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
`endif
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
`ifdef SEL_GAP_EN
            // The dead cycle arbitrates like IDLE so exactly one invalid cycle separates grants.
            GAP: begin
                if (win_any) begin
                    do_arb = 1'b1;
                end else begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase

        if (do_arb) begin
            sel_next   = win_idx;
            valid_next = 1'b1;
            cnt_next   = CNT_LOAD;
            ptr_next   = win_idx + 2'd1;
            state_next = GRANT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 2'b00;
            valid_reg <= 1'b0;
            ptr_reg   <= 2'b00;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.sel       = sel_reg;
    assign bus.sel_valid = valid_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule
